// File: rtl/hpdcache_req_arbiter.sv
// hpdcache_req_arbiter
// Round-robin arbiter merging N_REQ core-side request streams into a single
// registered request stream toward the cache controller. One output register
// slot; a new request may replace the slot in the same cycle it drains, so
// sustained throughput is one request per cycle.

package hpdcache_params_pkg;
    localparam int unsigned PARAM_REQ_SRC_ID_WIDTH = 3;
endpackage : hpdcache_params_pkg

module hpdcache_req_arbiter #(
    parameter int unsigned N_REQ         = 4,
    parameter int unsigned PAYLOAD_WIDTH = 128,
    parameter int unsigned SRC_ID_WIDTH  = hpdcache_params_pkg::PARAM_REQ_SRC_ID_WIDTH
) (
    input  logic                             clk_i,
    input  logic                             rst_i,

    input  logic [N_REQ-1:0]                 req_valid_i,
    output logic [N_REQ-1:0]                 req_ready_o,
    input  logic [N_REQ*PAYLOAD_WIDTH-1:0]   req_payload_i,

    output logic                             out_valid_o,
    input  logic                             out_ready_i,
    output logic [PAYLOAD_WIDTH-1:0]         out_payload_o,
    output logic [SRC_ID_WIDTH-1:0]          out_src_id_o
);

    localparam int unsigned PTR_W = $clog2(N_REQ);

    // Elaboration-time parameter sanity checks.
    if (N_REQ < 2 || N_REQ > 8) begin : g_bad_n_req
        $error("hpdcache_req_arbiter: N_REQ must be within 2..8");
    end
    if (N_REQ > (2 ** SRC_ID_WIDTH)) begin : g_bad_src_id_width
        $error("hpdcache_req_arbiter: SRC_ID_WIDTH too narrow for N_REQ");
    end

    // Registered state
    logic                       out_valid_q,   out_valid_d;
    logic [PAYLOAD_WIDTH-1:0]   out_payload_q, out_payload_d;
    logic [SRC_ID_WIDTH-1:0]    out_src_id_q,  out_src_id_d;
    logic [PTR_W-1:0]           rr_ptr_q,      rr_ptr_d;

    // Arbitration signals
    logic [N_REQ-1:0]           hi_mask;
    logic [N_REQ-1:0]           req_hi;
    logic [N_REQ-1:0]           pick;
    logic [N_REQ-1:0]           grant_oh;
    logic [PTR_W-1:0]           grant_idx;
    logic [PAYLOAD_WIDTH-1:0]   grant_payload;
    logic                       slot_free;
    logic                       accept;
    logic [N_REQ-1:0]           req_ready;

    // The output slot can take a new request when it is empty or draining now.
    assign slot_free = !out_valid_q || out_ready_i;

    // Round-robin pick: lowest valid index at or above rr_ptr, otherwise the
    // lowest valid index overall (wrap-around). Depends only on valids.
    always_comb begin
        hi_mask   = '0;
        grant_oh  = '0;
        grant_idx = '0;
        for (int k = 0; k < int'(N_REQ); k++) begin
            hi_mask[k] = (PTR_W'(k) >= rr_ptr_q);
        end
        req_hi = req_valid_i & hi_mask;
        pick   = (|req_hi) ? req_hi : req_valid_i;
        for (int k = int'(N_REQ) - 1; k >= 0; k--) begin
            if (pick[k]) begin
                grant_oh    = '0;
                grant_oh[k] = 1'b1;
                grant_idx   = PTR_W'(k);
            end
        end
    end

    // Payload mux for the granted requester; kept off the ready path.
    always_comb begin
        grant_payload = '0;
        for (int k = 0; k < int'(N_REQ); k++) begin
            if (grant_oh[k]) begin
                grant_payload = req_payload_i[k*PAYLOAD_WIDTH +: PAYLOAD_WIDTH];
            end
        end
    end

    // Ready is the grant, gated by slot availability; silent during reset.
    always_comb begin
        req_ready = (slot_free && !rst_i) ? grant_oh : '0;
        accept    = |req_ready;
    end

    // Next-state for the output slot and the round-robin pointer.
    always_comb begin
        out_valid_d   = out_valid_q;
        out_payload_d = out_payload_q;
        out_src_id_d  = out_src_id_q;
        rr_ptr_d      = rr_ptr_q;
        if (accept) begin
            // Covers both an empty slot and replace-on-drain (no bubble).
            out_valid_d   = 1'b1;
            out_payload_d = grant_payload;
            out_src_id_d  = SRC_ID_WIDTH'(grant_idx);
            rr_ptr_d      = (grant_idx == PTR_W'(N_REQ - 1)) ? '0 : grant_idx + PTR_W'(1);
        end else if (out_valid_q && out_ready_i) begin
            out_valid_d = 1'b0;
        end
    end

    // State registers with synchronous reset; a pending output is discarded.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_valid_q   <= 1'b0;
            out_payload_q <= '0;
            out_src_id_q  <= '0;
            rr_ptr_q      <= '0;
        end else begin
            out_valid_q   <= out_valid_d;
            out_payload_q <= out_payload_d;
            out_src_id_q  <= out_src_id_d;
            rr_ptr_q      <= rr_ptr_d;
        end
    end

    assign req_ready_o   = req_ready;
    assign out_valid_o   = out_valid_q;
    assign out_payload_o = out_payload_q;
    assign out_src_id_o  = out_src_id_q;

endmodule : hpdcache_req_arbiter

// File: tb/tb_hpdcache_req_arbiter.sv
// Testbench for hpdcache_req_arbiter (N_REQ=4, PAYLOAD_WIDTH=128).
// Each table row is one clock cycle: inputs applied after the rising edge,
// outputs checked at the falling edge. Accepted requests are pushed to a
// scoreboard queue and popped when the output handshake completes.

module tb_hpdcache_req_arbiter;

    localparam int N  = 4;
    localparam int PW = 128;
    localparam int SW = 3;

    logic              clk_i;
    logic              rst_i;
    logic [N-1:0]      req_valid_i;
    logic [N-1:0]      req_ready_o;
    logic [N*PW-1:0]   req_payload_i;
    logic              out_valid_o;
    logic              out_ready_i;
    logic [PW-1:0]     out_payload_o;
    logic [SW-1:0]     out_src_id_o;

    hpdcache_req_arbiter #(
        .N_REQ         (N),
        .PAYLOAD_WIDTH (PW),
        .SRC_ID_WIDTH  (SW)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .req_valid_i   (req_valid_i),
        .req_ready_o   (req_ready_o),
        .req_payload_i (req_payload_i),
        .out_valid_o   (out_valid_o),
        .out_ready_i   (out_ready_i),
        .out_payload_o (out_payload_o),
        .out_src_id_o  (out_src_id_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    typedef struct {
        logic         rst;
        logic [N-1:0] vld;
        logic         ordy;
        logic [N-1:0] exp_rdy;
        logic         exp_ov;
        logic [SW-1:0] exp_src;
        logic         pl_zero;
    } vec_t;

    typedef struct {
        logic [SW-1:0] src;
        logic [PW-1:0] pl;
    } sb_t;

    vec_t vecs[$];
    sb_t  sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   cur_row  = -1;

    function automatic logic [PW-1:0] pl_of(input int k);
        logic [31:0] hi;
        logic [7:0]  lo;
        hi = 32'hC0DE_0000 + 32'(k);
        lo = 8'(8'hA9 + k);
        return {hi, 88'h0, lo};
    endfunction

    task automatic add(input logic rst, input logic [N-1:0] vld, input logic ordy,
                       input logic [N-1:0] exp_rdy, input logic exp_ov,
                       input logic [SW-1:0] exp_src, input logic pl_zero);
        vec_t v;
        v.rst = rst; v.vld = vld; v.ordy = ordy; v.exp_rdy = exp_rdy;
        v.exp_ov = exp_ov; v.exp_src = exp_src; v.pl_zero = pl_zero;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s row=%0d actual=%0h required=%0h", name, cur_row, act, exp);
        end
    endtask

    initial begin
        vec_t v;
        sb_t  e;

        //   rst   vld      ordy  exp_rdy  ov    src   pl_zero
        // reset
        add(1'b1, 4'b1111, 1'b1, 4'b0000, 1'b0, 3'd0, 1'b1);  // 0
        add(1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 3'd0, 1'b1);  // 1
        // fairness, all valid: 0,1,2,3,0
        add(1'b0, 4'b1111, 1'b1, 4'b0001, 1'b0, 3'd0, 1'b0);  // 2
        add(1'b0, 4'b1111, 1'b1, 4'b0010, 1'b1, 3'd0, 1'b0);  // 3
        add(1'b0, 4'b1111, 1'b1, 4'b0100, 1'b1, 3'd1, 1'b0);  // 4
        add(1'b0, 4'b1111, 1'b1, 4'b1000, 1'b1, 3'd2, 1'b0);  // 5
        add(1'b0, 4'b1111, 1'b1, 4'b0001, 1'b1, 3'd3, 1'b0);  // 6
        add(1'b0, 4'b0000, 1'b1, 4'b0000, 1'b1, 3'd0, 1'b0);  // 7
        add(1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 3'd0, 1'b0);  // 8
        // single request from requester 2 (payload low byte 0xAB)
        add(1'b0, 4'b0100, 1'b1, 4'b0100, 1'b0, 3'd0, 1'b0);  // 9
        add(1'b0, 4'b0000, 1'b1, 4'b0000, 1'b1, 3'd2, 1'b0);  // 10
        // wrap-around from rr_ptr=3 with valid 1010: 3,1,3
        add(1'b0, 4'b1010, 1'b1, 4'b1000, 1'b0, 3'd0, 1'b0);  // 11
        add(1'b0, 4'b1010, 1'b1, 4'b0010, 1'b1, 3'd3, 1'b0);  // 12
        add(1'b0, 4'b1010, 1'b1, 4'b1000, 1'b1, 3'd1, 1'b0);  // 13
        add(1'b0, 4'b0000, 1'b1, 4'b0000, 1'b1, 3'd3, 1'b0);  // 14
        add(1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 3'd0, 1'b0);  // 15
        // backpressure with src 1 held for 3 cycles, then grant 2
        add(1'b0, 4'b0010, 1'b1, 4'b0010, 1'b0, 3'd0, 1'b0);  // 16
        add(1'b0, 4'b1111, 1'b0, 4'b0000, 1'b1, 3'd1, 1'b0);  // 17
        add(1'b0, 4'b1111, 1'b0, 4'b0000, 1'b1, 3'd1, 1'b0);  // 18
        add(1'b0, 4'b1111, 1'b0, 4'b0000, 1'b1, 3'd1, 1'b0);  // 19
        add(1'b0, 4'b1111, 1'b1, 4'b0100, 1'b1, 3'd1, 1'b0);  // 20
        add(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b1, 3'd2, 1'b0);  // 21
        // reset while output pending and stalled
        add(1'b1, 4'b1111, 1'b0, 4'b0000, 1'b1, 3'd2, 1'b0);  // 22
        add(1'b0, 4'b1111, 1'b0, 4'b0001, 1'b0, 3'd0, 1'b1);  // 23
        add(1'b0, 4'b0000, 1'b1, 4'b0000, 1'b1, 3'd0, 1'b0);  // 24
        add(1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 3'd0, 1'b0);  // 25

        for (int k = 0; k < N; k++) begin
            req_payload_i[k*PW +: PW] = pl_of(k);
        end
        rst_i       = 1'b1;
        req_valid_i = '0;
        out_ready_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;

        for (int i = 0; i < vecs.size(); i++) begin
            v           = vecs[i];
            cur_row     = i;
            rst_i       = v.rst;
            req_valid_i = v.vld;
            out_ready_i = v.ordy;
            @(negedge clk_i);

            chk("req_ready", PW'(req_ready_o), PW'(v.exp_rdy));
            chk("out_valid", PW'(out_valid_o), PW'(v.exp_ov));
            if (v.exp_ov || v.pl_zero)
                chk("out_src_id", PW'(out_src_id_o), PW'(v.exp_src));
            if (v.exp_ov)
                chk("out_payload", out_payload_o, pl_of(int'(v.exp_src)));
            if (v.pl_zero)
                chk("out_payload_zero", out_payload_o, '0);

            // Output handshake drains the oldest expected request.
            if (out_valid_o && out_ready_i) begin
                if (sb.size() == 0) begin
                    chk("sb_underflow", PW'(1), PW'(0));
                end else begin
                    e = sb.pop_front();
                    chk("sb_src", PW'(out_src_id_o), PW'(e.src));
                    chk("sb_payload", out_payload_o, e.pl);
                end
            end
            // Expected accept this cycle becomes a future output.
            for (int j = 0; j < N; j++) begin
                if (!v.rst && v.vld[j] && v.exp_rdy[j]) begin
                    e.src = SW'(j);
                    e.pl  = pl_of(j);
                    sb.push_back(e);
                end
            end
            if (v.rst) sb.delete();

            @(posedge clk_i);
            #1;
        end

        cur_row = -1;
        chk("sb_drain", PW'(sb.size()), PW'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_hpdcache_req_arbiter

// File: doc/hpdcache_req_arbiter.md
HPDCACHE_REQ_ARBITER -- requirements
Module: hpdcache_req_arbiter

Interface
REQ-001 The block SHALL have parameter N_REQ, default 4, giving the number of core-side requesters (2..8).
REQ-002 The block SHALL have parameter PAYLOAD_WIDTH, default 128, giving the opaque request payload width in bits.
REQ-003 The block SHALL have parameter SRC_ID_WIDTH, default hpdcache_params_pkg::PARAM_REQ_SRC_ID_WIDTH (3), giving the source-ID width; elaboration SHALL fail if N_REQ > 2**SRC_ID_WIDTH.
REQ-004 The block SHALL have one clock; reset is synchronous and active-high.
REQ-005 The block SHALL have port clk_i  input  1  clock, all state on the rising edge.
REQ-006 The block SHALL have port rst_i  input  1  synchronous active-high reset.
REQ-007 The block SHALL have port req_valid_i  input  N_REQ  per-requester request valid.
REQ-008 The block SHALL have port req_ready_o  output  N_REQ  per-requester accept, at most one bit set.
REQ-009 The block SHALL have port req_payload_i  input  N_REQ*PAYLOAD_WIDTH  payloads, requester k at bits [k*PAYLOAD_WIDTH +: PAYLOAD_WIDTH].
REQ-010 The block SHALL have port out_valid_o  output  1  registered request valid toward the cache controller.
REQ-011 The block SHALL have port out_ready_i  input  1  cache controller accept.
REQ-012 The block SHALL have port out_payload_o  output  PAYLOAD_WIDTH  registered payload of the granted request.
REQ-013 The block SHALL have port out_src_id_o  output  SRC_ID_WIDTH  index of the granted requester, zero-extended.

Function
REQ-014 The block SHALL hold one output register (valid, payload, src_id) and a round-robin pointer rr_ptr of width clog2(N_REQ).
REQ-015 The block SHALL define slot_free = !out_valid_o || out_ready_i, combinationally.
REQ-016 When slot_free, the block SHALL grant the first k with req_valid_i[k]=1, searching k = rr_ptr, rr_ptr+1, ... modulo N_REQ.
REQ-017 The block SHALL drive req_ready_o[k]=1 only for the granted k while slot_free, and all zeros otherwise; req_ready_o SHALL never depend on req_payload_i.
REQ-018 On accept (req_valid_i[k] && req_ready_o[k]), the block SHALL load out_payload_o with payload k, load out_src_id_o with k, and set out_valid_o=1 at the next edge; latency is 1 cycle.
REQ-019 On accept of k, the block SHALL set rr_ptr to (k+1) mod N_REQ; with no accept, rr_ptr SHALL hold.
REQ-020 When out_valid_o && out_ready_i and no request is accepted in the same cycle, the block SHALL clear out_valid_o at the next edge.
REQ-021 When out_valid_o && out_ready_i and a request is accepted in the same cycle, the block SHALL replace the output with the new request so that throughput is 1 request per cycle with no bubble.
REQ-022 While out_valid_o && !out_ready_i, the block SHALL keep out_valid_o, out_payload_o and out_src_id_o stable and SHALL drive req_ready_o to all zeros.
REQ-023 The block SHALL NOT drop, duplicate or reorder an accepted request; a requester with req_valid_i held high SHALL be granted within N_REQ accepts.
REQ-024 The block SHALL tolerate req_valid_i deassertion without ready (no requester protocol checking); such a request is simply not granted.

Reset
REQ-025 While rst_i=1 at a clock edge, the block SHALL set out_valid_o=0, out_payload_o=0, out_src_id_o=0 and rr_ptr=0.
REQ-026 Reset asserted while out_valid_o=1 SHALL discard the pending output without a handshake; req_ready_o SHALL be all zeros during any cycle with rst_i=1.

Verification
REQ-027 The bench SHALL cover reset: after rst_i pulse with req_valid_i=0 -> out_valid_o=0, out_payload_o=0, out_src_id_o=0, req_ready_o=0000.
REQ-028 The bench SHALL cover a single request: req_valid_i=0100, payload[2]=0xAB, out_ready_i=1 -> req_ready_o=0100 same cycle; next cycle out_valid_o=1, out_payload_o=0xAB, out_src_id_o=2.
REQ-029 The bench SHALL cover fairness: req_valid_i=1111 held, out_ready_i=1 -> out_src_id_o sequence 0,1,2,3,0 on consecutive cycles with out_valid_o continuously 1.
REQ-030 The bench SHALL cover backpressure: output valid with src 1, out_ready_i=0 for 3 cycles, req_valid_i=1111 -> req_ready_o=0000 and outputs stable; on out_ready_i=1 -> req_ready_o=0100 same cycle and out_src_id_o=2 next cycle.
REQ-031 The bench SHALL cover wrap-around: rr_ptr=3, req_valid_i=1010 -> grant 3 first, then 1, then 3.
REQ-032 The bench SHALL cover reset mid-operation: out_valid_o=1, out_ready_i=0, rst_i=1 for 1 cycle -> out_valid_o=0 next cycle and first subsequent grant taken from requester 0 if it is valid.
